// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM address sequencer.
//   seq_state_t  : controller state encoding (2 bits)
//   AW_DEF       : default ROM address width
//   LCW_DEF      : default loop-counter width
//   ADDR_MAX     : widest address the helper adder supports
//   window_addr(): base + offset; callers truncate to their own width, which
//                  gives the modulo-2**AW wrap across the top of the ROM.
package rom_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam int AW_DEF   = 4;
   localparam int LCW_DEF  = 4;
   localparam int ADDR_MAX = 16;

   function automatic logic [ADDR_MAX-1:0] window_addr(
      input logic [ADDR_MAX-1:0] base,
      input logic [ADDR_MAX-1:0] offset
   );
      return base + offset;
   endfunction

endpackage

// File: rtl/seq_offset_counter.sv
// Offset register for the scan window.
//   clk    : clock
//   rst    : synchronous active-high reset (offset -> 0)
//   clr    : load 0 (takes priority over en)
//   en     : increment by one
//   len    : window length minus one
//   offset : current offset
//   tc     : offset has reached len (last word of the window)
module seq_offset_counter
   import rom_seq_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] offset,
   output logic          tc
);

   logic [AW-1:0] offset_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         offset_reg <= '0;
      end else if (clr) begin
         offset_reg <= '0;
      end else if (en) begin
         offset_reg <= offset_reg + AW'(1);
      end
   end

   assign offset = offset_reg;
   assign tc     = (offset_reg == len);

endmodule

// File: rtl/rom_addr_sequencer.sv
// Sequences ROM addresses over a programmed window base..base+len, once or
// looping, pacing reads against a valid/ready consumer (1-cycle ROM latency,
// at most one word in flight).
//   clk, rst           : clock, synchronous active-high reset
//   cfg_load/base/len  : capture window (IDLE only)
//   loop_en            : wrap to base after the last word
//   start, abort       : begin scan (IDLE only) / return to IDLE from anywhere
//   rd_ready           : consumer accepts the word on the bus
//   rom_en, rom_addr   : ROM read strobe and address
//   rd_valid           : ROM data on bus is a valid, unconsumed word
//   busy, done         : not IDLE / one-cycle end-of-scan pulse
//   loop_cnt           : completed wraps, saturating, cleared on start
module rom_addr_sequencer
   import rom_seq_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int LCW = LCW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_load,
   input  logic [AW-1:0]  cfg_base,
   input  logic [AW-1:0]  cfg_len,
   input  logic           loop_en,
   input  logic           start,
   input  logic           abort,
   input  logic           rd_ready,
   output logic           rom_en,
   output logic [AW-1:0]  rom_addr,
   output logic           rd_valid,
   output logic           busy,
   output logic           done,
   output logic [LCW-1:0] loop_cnt
);

   seq_state_t     state_reg, state_next;
   logic [AW-1:0]  base_reg, len_reg, offset;
   logic [LCW-1:0] loop_cnt_reg;
   logic           rd_valid_reg;
   logic           rom_en_int, start_ok, tc;
   logic           advance, wrap, cfg_ok;

   always_comb begin
      state_next = state_reg;
      rom_en_int = 1'b0;
      start_ok   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               start_ok   = 1'b1;
            end
         end
         ST_RUN: begin
            // Issue a read whenever the single output slot is free or
            // being emptied this cycle.
            rom_en_int = !rd_valid_reg || rd_ready;
            if (rom_en_int && tc && !loop_en) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rd_valid_reg && rd_ready) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // abort overrides everything, including a same-cycle start.
      if (abort) begin
         state_next = ST_IDLE;
         start_ok   = 1'b0;
      end
   end

   // Offset/loop bookkeeping is frozen by abort so the aborted read leaves
   // no trace; a non-loop scan parks offset at len so rom_addr holds.
   assign advance = rom_en_int && !abort;
   assign wrap    = advance && tc && loop_en;
   assign cfg_ok  = cfg_load && (state_reg == ST_IDLE);

   seq_offset_counter #(
      .AW (AW)
   ) u_offset (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok || wrap),
      .en     (advance && !tc),
      .len    (len_reg),
      .offset (offset),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         base_reg     <= '0;
         len_reg      <= '0;
         rd_valid_reg <= 1'b0;
         loop_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (cfg_ok) begin
            base_reg <= cfg_base;
            len_reg  <= cfg_len;
         end
         if (abort) begin
            rd_valid_reg <= 1'b0;
         end else begin
            rd_valid_reg <= rom_en_int || (rd_valid_reg && !rd_ready);
         end
         if (start_ok) begin
            loop_cnt_reg <= '0;
         end else if (wrap && (loop_cnt_reg != '1)) begin
            loop_cnt_reg <= loop_cnt_reg + LCW'(1);
         end
      end
   end

   assign rom_en   = rom_en_int;
   assign rom_addr = AW'(window_addr(ADDR_MAX'(base_reg), ADDR_MAX'(offset)));
   assign rd_valid = rd_valid_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign loop_cnt = loop_cnt_reg;

endmodule
